// File: rtl/cello_tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweep checker.
// Any module that sizes itself from N_IN goes through these helpers, so widths cannot drift apart.
package cello_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } tt_state_e;

  // Truth-table width for a given input count.
  function automatic int tt_w(input int n_in);
    return 1 << n_in;
  endfunction

  // Mismatch-counter width; must be able to hold the value TT_W itself.
  function automatic int cnt_w(input int n_in);
    return $clog2((1 << n_in) + 1);
  endfunction

  function automatic int popcount(input logic [255:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 256; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/cello_tt_sweep_checker_if.sv
// Control, result and CUT-facing signals of the sweep checker.
// The checker connects through the slave modport; its driver connects through master.
interface cello_tt_sweep_checker_if
  import cello_tt_pkg::*;
#(
  parameter int N_IN = 4
);
  localparam int TT_W  = tt_w(N_IN);
  localparam int CNT_W = cnt_w(N_IN);

  logic             start;
  logic             abort;
  logic [TT_W-1:0]  expected_tt;
  logic [N_IN-1:0]  dut_in;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [TT_W-1:0]  observed_tt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             fail_valid;
  logic [N_IN-1:0]  first_fail_idx;

  modport master (
    output start, abort, expected_tt, dut_out,
    input  dut_in, busy, done, pass, observed_tt, mismatch_cnt, fail_valid, first_fail_idx
  );

  modport slave (
    input  start, abort, expected_tt, dut_out,
    output dut_in, busy, done, pass, observed_tt, mismatch_cnt, fail_valid, first_fail_idx
  );
endinterface

// File: rtl/cello_tt_vec_seq.sv
// Vector sequencer: walks idx through 0..TT_W-1.
// Each vector is held SETTLE cycles, then a one-cycle SAMPLE strobe fires.
module cello_tt_vec_seq
  import cello_tt_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output tt_state_e       state,
  output logic [N_IN-1:0] idx,
  output logic            start_accept,
  output logic            sample_strobe,
  output logic            last
);
  localparam int              SC_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  tt_state_e       state_d;
  logic [N_IN-1:0] idx_d;
  logic [SC_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    cnt_d         = cnt_q;
    sample_strobe = 1'b0;
    start_accept  = start && (state == ST_IDLE || state == ST_DONE);
    last          = (idx == IDX_LAST);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SC_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          sample_strobe = 1'b1;
          cnt_d         = '0;
          if (last) begin
            // Park dut_in at 0 so the final vector is not held past its window.
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            state_d = ST_SETTLE;
            idx_d   = idx + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/cello_tt_sweep_checker.sv
// Truth-table sweep checker: drives every CUT input vector, compares each
// sampled output with the latched expected table, and reports the results.
module cello_tt_sweep_checker
  import cello_tt_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2,
  parameter int TT_W   = tt_w(N_IN),
  parameter int CNT_W  = cnt_w(N_IN)
) (
  input logic                   clk,
  input logic                   rst,
  cello_tt_sweep_checker_if.slave bus
);
  tt_state_e        state;
  logic [N_IN-1:0]  idx;
  logic             start_accept;
  logic             sample_strobe;
  logic             last;

  logic [TT_W-1:0]  exp_q;
  logic [TT_W-1:0]  obs_q;
  logic [CNT_W-1:0] mism_q;
  logic [CNT_W-1:0] mism_next;
  logic             fail_q;
  logic [N_IN-1:0]  ffi_q;
  logic             pass_q;
  logic             miss;

  cello_tt_vec_seq #(
    .N_IN  (N_IN),
    .SETTLE(SETTLE)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .start        (bus.start),
    .abort        (bus.abort),
    .state        (state),
    .idx          (idx),
    .start_accept (start_accept),
    .sample_strobe(sample_strobe),
    .last         (last)
  );

  // The current bit is folded in here so the final-edge pass decision sees it.
  always_comb begin
    miss      = bus.dut_out ^ exp_q[idx];
    mism_next = mism_q + CNT_W'(miss);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q  <= '0;
      obs_q  <= '0;
      mism_q <= '0;
      fail_q <= 1'b0;
      ffi_q  <= '0;
      pass_q <= 1'b0;
    end else if (start_accept) begin
      exp_q  <= bus.expected_tt;
      obs_q  <= '0;
      mism_q <= '0;
      fail_q <= 1'b0;
      ffi_q  <= '0;
      pass_q <= 1'b0;
    end else if (sample_strobe) begin
      obs_q[idx] <= bus.dut_out;
      mism_q     <= mism_next;
      if (miss && !fail_q) begin
        fail_q <= 1'b1;
        ffi_q  <= idx;
      end
      if (last) pass_q <= (mism_next == '0);
    end
  end

  // Abort leaves the partial results in place for debug.
  assign bus.dut_in         = idx;
  assign bus.busy           = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign bus.done           = (state == ST_DONE);
  assign bus.pass           = pass_q;
  assign bus.observed_tt    = obs_q;
  assign bus.mismatch_cnt   = mism_q;
  assign bus.fail_valid     = fail_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_cello_tt_sweep_checker.sv
// Directed bench for cello_tt_sweep_checker: N_IN=4/SETTLE=2 and N_IN=3/SETTLE=1 instances.
module tb_cello_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cello_tt_sweep_checker_if #(.N_IN(4)) b1 ();
  cello_tt_sweep_checker_if #(.N_IN(3)) b2 ();

  cello_tt_sweep_checker #(.N_IN(4), .SETTLE(2)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  cello_tt_sweep_checker #(.N_IN(3), .SETTLE(1)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  // CUT models: mode 0 ideal, 1 stuck at 0, 2 ideal with vector 7 inverted.
  logic [15:0] cut_tt  = 16'h0000;
  logic [7:0]  cut2_tt = 8'h00;
  int          mode    = 0;

  always_comb begin
    if (mode == 1) b1.dut_out = 1'b0;
    else           b1.dut_out = cut_tt[b1.dut_in] ^ ((mode == 2) && (b1.dut_in == 4'd7));
    b2.dut_out = cut2_tt[b2.dut_in];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full N_IN=4 sweep; optional spurious start pulses at relative edges pa/pb
  // arrive with a corrupted expected table that must not be latched.
  task automatic sweep(input string tag, input logic [15:0] exp_tt, input int m,
                       input int pa, input int pb);
    int seq_err;
    seq_err        = 0;
    cut_tt         = exp_tt;
    mode           = m;
    b1.expected_tt = exp_tt;
    b1.start       = 1'b1;
    tick();
    b1.start = 1'b0;
    check({tag, "_busy"}, b1.busy, 1);
    check({tag, "_done_lo"}, b1.done, 0);
    if (b1.dut_in !== 4'd0) seq_err++;
    for (int j = 1; j < 48; j++) begin
      if (j == pa || j == pb) begin
        b1.start       = 1'b1;
        b1.expected_tt = ~exp_tt;
      end
      tick();
      b1.start       = 1'b0;
      b1.expected_tt = exp_tt;
      if (b1.dut_in !== 4'(j / 3)) seq_err++;
      if (b1.done !== 1'b0 || b1.busy !== 1'b1) seq_err++;
    end
    tick();
    check({tag, "_seq"}, seq_err, 0);
    check({tag, "_done"}, b1.done, 1);
    check({tag, "_busy_lo"}, b1.busy, 0);
  endtask

  initial begin
    int err2;
    rst            = 1'b1;
    b1.start       = 1'b0;
    b1.abort       = 1'b0;
    b1.expected_tt = '0;
    b2.start       = 1'b0;
    b2.abort       = 1'b0;
    b2.expected_tt = '0;
    #2;
    check("rst_busy", b1.busy, 0);
    check("rst_done", b1.done, 0);
    check("rst_pass", b1.pass, 0);
    check("rst_obs", b1.observed_tt, 0);
    check("rst_cnt", b1.mismatch_cnt, 0);
    check("rst_fv", b1.fail_valid, 0);
    check("rst_ffi", b1.first_fail_idx, 0);
    check("rst_din", b1.dut_in, 0);
    check("rst2_done", b2.done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ideal CUT
    sweep("ideal", 16'h0239, 0, -1, -1);
    check("ideal_pass", b1.pass, 1);
    check("ideal_obs", b1.observed_tt, 16'h0239);
    check("ideal_cnt", b1.mismatch_cnt, 0);
    check("ideal_fv", b1.fail_valid, 0);

    // Abort in DONE has no effect
    b1.abort = 1'b1;
    tick();
    b1.abort = 1'b0;
    check("idle_abort_done", b1.done, 1);
    check("idle_abort_pass", b1.pass, 1);

    // Stuck-at-0 CUT
    sweep("stuck", 16'h0239, 1, -1, -1);
    check("stuck_pass", b1.pass, 0);
    check("stuck_obs", b1.observed_tt, 16'h0000);
    check("stuck_cnt", b1.mismatch_cnt, 5);
    check("stuck_fv", b1.fail_valid, 1);
    check("stuck_ffi", b1.first_fail_idx, 0);

    // Vector 7 inverted
    sweep("flip7", 16'h0239, 2, -1, -1);
    check("flip7_pass", b1.pass, 0);
    check("flip7_obs", b1.observed_tt, 16'h02B9);
    check("flip7_cnt", b1.mismatch_cnt, 1);
    check("flip7_fv", b1.fail_valid, 1);
    check("flip7_ffi", b1.first_fail_idx, 7);

    // Start pulses at edges 5 and 20 are ignored
    sweep("busy_start", 16'h0239, 0, 5, 20);
    check("busy_start_pass", b1.pass, 1);
    check("busy_start_obs", b1.observed_tt, 16'h0239);

    // Start while DONE restarts at once
    sweep("restart", 16'h0239, 0, -1, -1);
    check("restart_pass", b1.pass, 1);

    // Abort (with simultaneous start) at edge 20 of a stuck-at-0 sweep
    cut_tt         = 16'h0239;
    mode           = 1;
    b1.expected_tt = 16'h0239;
    b1.start       = 1'b1;
    tick();
    b1.start = 1'b0;
    repeat (19) tick();
    b1.abort = 1'b1;
    b1.start = 1'b1;
    tick();
    b1.abort = 1'b0;
    b1.start = 1'b0;
    check("abort_busy", b1.busy, 0);
    check("abort_done", b1.done, 0);
    check("abort_pass", b1.pass, 0);
    check("abort_din", b1.dut_in, 0);
    check("abort_cnt", b1.mismatch_cnt, 4);
    check("abort_fv", b1.fail_valid, 1);
    check("abort_ffi", b1.first_fail_idx, 0);
    tick();
    check("abort_start_lost", b1.busy, 0);

    // Second sweep, reset asynchronously partway through
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    repeat (10) tick();
    check("pre_rst_cnt", b1.mismatch_cnt, 1);
    check("pre_rst_din", b1.dut_in, 3);
    rst = 1'b1;
    #1;
    check("arst_busy", b1.busy, 0);
    check("arst_din", b1.dut_in, 0);
    check("arst_cnt", b1.mismatch_cnt, 0);
    check("arst_fv", b1.fail_valid, 0);
    check("arst_ffi", b1.first_fail_idx, 0);
    check("arst_obs", b1.observed_tt, 0);
    @(negedge clk);
    rst = 1'b0;

    // N_IN=3, SETTLE=1 instance
    err2           = 0;
    cut2_tt        = 8'hA5;
    b2.expected_tt = 8'hA5;
    b2.start       = 1'b1;
    tick();
    b2.start = 1'b0;
    check("n3_busy", b2.busy, 1);
    for (int j = 1; j < 16; j++) begin
      tick();
      if (b2.done !== 1'b0 || b2.dut_in !== 3'(j / 2)) err2++;
    end
    tick();
    check("n3_seq", err2, 0);
    check("n3_done", b2.done, 1);
    check("n3_pass", b2.pass, 1);
    check("n3_obs", b2.observed_tt, 8'hA5);
    check("n3_cnt", b2.mismatch_cnt, 0);
    check("n3_fv", b2.fail_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cello_tt_sweep_checker.md
Name: cello_tt_sweep_checker

Overview:
- Sequential truth-table verifier for synthesized NOR/NOT logic circuits with parametrised input count.
- Steps the circuit under test (CUT) through all 2^N_IN input combinations and waits a programmable settle time per vector.
- Samples the CUT output, compares it with an expected hex truth table, and reports the observed table, mismatch count and first failing index.
- Sits beside any generated logic module as a self-check / characterisation harness.

Parameters:
- N_IN, 4, number of CUT inputs (1..8).
- TT_W, 2**N_IN, truth-table width (derived; do not override).
- SETTLE, 2, cycles held per vector before sampling (>=1).
- CNT_W, $clog2(TT_W+1), width of mismatch_cnt.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a sweep when idle.
- abort  in  1  terminates a sweep in progress.
- expected_tt  in  TT_W  expected output; bit i = CUT output for input vector i. Latched at start.
- dut_in  out  N_IN  vector applied to the CUT; dut_in[N_IN-1] is the first-listed CUT input.
- dut_out  in  1  CUT output (synchronous to clk; no synchroniser inside).
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; level, held until next accepted start, abort or reset.
- pass  out  1  valid with done; 1 iff mismatch_cnt==0.
- observed_tt  out  TT_W  captured CUT outputs.
- mismatch_cnt  out  CNT_W  number of differing bits.
- fail_valid  out  1  at least one mismatch captured.
- first_fail_idx  out  N_IN  lowest mismatching vector index.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, including dut_in, busy, done, pass, observed_tt, mismatch_cnt, fail_valid and first_fail_idx. Latched expected table is 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE, start=1 at edge E0:
  - latch expected_tt;
  - clear observed_tt, mismatch_cnt, fail_valid, first_fail_idx, done, pass;
  - dut_in=0, settle counter=0, busy=1, go to SETTLE.
- SETTLE: counter increments each cycle. After SETTLE cycles in the state, go to SAMPLE.
- SAMPLE (one cycle):
  - observed_tt[idx] <= dut_out.
  - If dut_out != exp[idx], increment mismatch_cnt. If fail_valid was 0, also set fail_valid=1 and first_fail_idx=idx.
  - If idx==TT_W-1: go to DONE with busy=0, done=1, and pass = (final count==0), all at the same edge.
  - Otherwise idx++ (dut_in updates at that edge), clear the counter, return to SETTLE.
- Timing:
  - Vector k is sampled at edge E0+(k+1)*(SETTLE+1).
  - done rises at edge E0+TT_W*(SETTLE+1); this is 48 for N_IN=4, SETTLE=2.
  - dut_in is stable for exactly SETTLE+1 cycles per vector.
- The comparison uses the dut_out value present at the SAMPLE edge. The same-edge count update must include the current bit; pass must not be computed one cycle late.
- start while busy: ignored, with no restart and no latch.
- start in DONE: a new sweep begins, and done drops at the accepting edge.
- abort while busy: next edge goes to IDLE. busy=0, done=0, pass=0, dut_in=0. Partial observed_tt, mismatch_cnt and fail fields hold their values for debug.
- abort in IDLE/DONE: no effect.
- abort and start in the same cycle: abort wins when busy. When idle, start wins.
- rst mid-sweep: immediate return to the reset values.
- mismatch_cnt saturates naturally; its maximum is TT_W, and CNT_W covers it.
- idx wrap never occurs. The sweep terminates at TT_W-1.

Decomposition:
- Shared package cello_tt_pkg:
  - state enum tt_state_e {IDLE, SETTLE, SAMPLE, DONE};
  - function popcount for bench/reference use;
  - localparam helpers for TT_W and CNT_W.
- One natural sub-module, cello_tt_vec_seq:
  - owns idx, the settle counter and the SETTLE/SAMPLE sequencing;
  - emits a sample_strobe and the current idx.
- The top level holds the comparison, result registers and handshake.

Test Plan:
- N_IN=4, SETTLE=2, expected_tt=16'h0239, CUT modelled as ideal 0x0239 function of dut_in → done at edge 48, pass=1, observed_tt=16'h0239, mismatch_cnt=0, fail_valid=0.
- Same expected table, dut_out stuck at 0 → observed_tt=16'h0000, mismatch_cnt=5, fail_valid=1, first_fail_idx=0, pass=0.
- CUT with only vector 7 inverted (observed 16'h02B9) → mismatch_cnt=1, first_fail_idx=7. dut_in holds each value exactly 3 cycles, and the sequence is 0..15 in order.
- start pulsed at edges 5 and 20 of a running sweep → both ignored and done still at edge 48. start while done → done drops at once and the new sweep completes 48 edges later.
- abort at edge 20, then rst asserted asynchronously mid-second-sweep → after abort: busy=0, done=0, dut_in=0, partial counts held. After rst: all outputs 0 without waiting for a clock edge.
- N_IN=3, SETTLE=1, expected_tt=8'hA5, ideal CUT → done at edge 16, pass=1, observed_tt=8'hA5.
